spi_regfile_slave: RTL and testbench

//  Second-generation front-panel SPI slave: oversamples the SPI pins on the system clock, so it has no SCLK-domain logic.

---
 rtl/spi_regfile_slave.sv | 173 +++++++++++++++++
 tb/tb_spi_regfile_slave.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_regfile_slave.sv
// Oversampled SPI slave with a small register file: LED port, PWM duty channels,
// chip ID and sticky status. Every SPI pin is synchronised into CLK; there is no SCLK-domain logic.
module spi_regfile_slave #(
   parameter int          LED_W       = 4,
   parameter int          NUM_PWM     = 2,
   parameter int          LSB_FIRST   = 1,
   parameter logic [7:0]  CHIP_ID     = 8'h71,
   parameter logic [7:0]  CMD_WR_LED  = 8'h01,
   parameter logic [7:0]  CMD_RD_LED  = 8'h02,
   parameter logic [7:0]  CMD_WR_PWM  = 8'h04,
   parameter logic [7:0]  CMD_RD_PWM  = 8'h05,
   parameter logic [7:0]  CMD_RD_ID   = 8'h06,
   parameter logic [7:0]  CMD_RD_STAT = 8'h07
) (
   input  logic                 CLK,
   input  logic                 NRST,
   input  logic                 SPI_SCLK,
   input  logic                 SPI_MOSI,
   input  logic                 SPI_SS,
   output logic                 SPI_MISO,
   output logic                 MISO_OE,
   output logic [LED_W-1:0]     LEDPORT,
   output logic [8*NUM_PWM-1:0] PWMPORT,
   output logic                 WR_STB,
   output logic [1:0]           fsm_state
);

   typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, DATA = 2'd2, DISCARD = 2'd3} state_t;
   localparam int IW = (NUM_PWM > 1) ? $clog2(NUM_PWM) : 1;

   state_t           state_q, state_d;
   logic [1:0]       sclk_sync, ss_sync, mosi_sync;
   logic             sclk_d, ss_d;
   logic [1:0]       prime_q;
   logic             armed_q;
   logic [2:0]       bit_cnt;
   logic [6:0]       rx_sr;
   logic [7:0]       tx_sr, tx_val, cmd_q, cmd_sel, rx_byte;
   logic             miso_q, wr_stb_q, err_q, ovr_q;
   logic [LED_W-1:0] led_q;
   logic [7:0]       pwm_q [NUM_PWM];
   logic [IW-1:0]    idx_q, idx_next;

   logic sclk_s, ss_s, mosi_s, ss_low;
   logic sclk_rise, sclk_fall, ss_rise, ss_fall;
   logic active, bit_tick, byte_done, tx_load;
   logic wr_led, wr_pwm, rd_pwm, rd_stat, cmd_ok;

   function automatic logic cmd_known(input logic [7:0] c);
      return (c == CMD_WR_LED) || (c == CMD_RD_LED) || (c == CMD_WR_PWM) ||
             (c == CMD_RD_PWM) || (c == CMD_RD_ID)  || (c == CMD_RD_STAT);
   endfunction

   assign sclk_s    = sclk_sync[1];
   assign ss_s      = ss_sync[1];
   assign mosi_s    = mosi_sync[1];
   assign ss_low    = ~ss_s;
   assign sclk_rise = sclk_s & ~sclk_d;
   assign sclk_fall = ~sclk_s & sclk_d;
   assign ss_rise   = ss_s & ~ss_d;
   // The reset value of the SS synchroniser is not a real sample, so a frame
   // only starts after SS has genuinely been seen high since reset.
   assign ss_fall   = armed_q & ss_low & ss_d;

   assign active    = (state_q != IDLE);
   assign bit_tick  = sclk_rise & ss_low & active;
   assign byte_done = bit_tick & (bit_cnt == 3'd7);
   assign rx_byte   = (LSB_FIRST != 0) ? {mosi_s, rx_sr} : {rx_sr, mosi_s};
   assign cmd_ok    = cmd_known(rx_byte);
   assign cmd_sel   = (state_q == CMD) ? rx_byte : cmd_q;
   assign tx_load   = byte_done & (((state_q == CMD) & cmd_ok) | (state_q == DATA));
   assign wr_led    = byte_done & (state_q == DATA) & (cmd_q == CMD_WR_LED);
   assign wr_pwm    = byte_done & (state_q == DATA) & (cmd_q == CMD_WR_PWM);
   assign rd_pwm    = tx_load & (cmd_sel == CMD_RD_PWM);
   assign rd_stat   = tx_load & (cmd_sel == CMD_RD_STAT);
   assign idx_next  = (idx_q == IW'(NUM_PWM - 1)) ? '0 : idx_q + 1'b1;

   always_comb begin
      tx_val = '0;
      if (cmd_sel == CMD_RD_ID)        tx_val = CHIP_ID;
      else if (cmd_sel == CMD_RD_LED)  tx_val[LED_W-1:0] = led_q;
      else if (cmd_sel == CMD_RD_PWM)  tx_val = pwm_q[idx_q];
      else if (cmd_sel == CMD_RD_STAT) tx_val = {6'b0, ovr_q, err_q};
   end

   always_comb begin
      state_d = state_q;
      if (ss_rise) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (ss_fall) state_d = CMD;
            CMD:     if (byte_done) state_d = cmd_ok ? DATA : DISCARD;
            default: state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST) begin
         sclk_sync <= 2'b00;
         ss_sync   <= 2'b11;
         mosi_sync <= 2'b00;
         sclk_d    <= 1'b0;
         ss_d      <= 1'b1;
         prime_q   <= 2'b00;
         armed_q   <= 1'b0;
         bit_cnt   <= '0;
         rx_sr     <= '0;
         tx_sr     <= '0;
         cmd_q     <= '0;
         miso_q    <= 1'b0;
         idx_q     <= '0;
         wr_stb_q  <= 1'b0;
         led_q     <= '0;
         err_q     <= 1'b0;
         ovr_q     <= 1'b0;
         for (int i = 0; i < NUM_PWM; i++) pwm_q[i] <= '0;
      end else begin
         sclk_sync <= {sclk_sync[0], SPI_SCLK};
         ss_sync   <= {ss_sync[0], SPI_SS};
         mosi_sync <= {mosi_sync[0], SPI_MOSI};
         sclk_d    <= sclk_s;
         ss_d      <= ss_s;
         prime_q   <= {prime_q[0], 1'b1};
         armed_q   <= armed_q | (prime_q[1] & ss_s);
         wr_stb_q  <= wr_led | wr_pwm;
         if (state_q == IDLE && ss_fall) begin
            bit_cnt <= '0;
            idx_q   <= '0;
            tx_sr   <= '0;
            miso_q  <= 1'b0;
         end else begin
            if (bit_tick) begin
               bit_cnt <= bit_cnt + 1'b1;
               rx_sr   <= (LSB_FIRST != 0) ? rx_byte[7:1] : rx_byte[6:0];
            end
            if (state_q == CMD && byte_done) cmd_q <= rx_byte;
            if (tx_load) begin
               tx_sr <= tx_val;
            end else if (sclk_fall && ss_low && active) begin
               miso_q <= (LSB_FIRST != 0) ? tx_sr[0] : tx_sr[7];
               tx_sr  <= (LSB_FIRST != 0) ? {1'b0, tx_sr[7:1]} : {tx_sr[6:0], 1'b0};
            end
            if (wr_pwm || rd_pwm) idx_q <= idx_next;
         end
         if (wr_led) led_q <= rx_byte[LED_W-1:0];
         if (wr_pwm) pwm_q[idx_q] <= rx_byte;
         // Status bits are cleared only after their old value has been loaded for transmit.
         if (state_q == CMD && byte_done && !cmd_ok) err_q <= 1'b1;
         else if (rd_stat)                           err_q <= 1'b0;
         if (sclk_rise && ss_rise) ovr_q <= 1'b1;
         else if (rd_stat)         ovr_q <= 1'b0;
      end
   end

   always_comb begin
      PWMPORT = '0;
      for (int i = 0; i < NUM_PWM; i++) PWMPORT[8*i +: 8] = pwm_q[i];
   end

   assign SPI_MISO  = miso_q & (state_q == DATA);
   assign MISO_OE   = ss_low;
   assign LEDPORT   = led_q;
   assign WR_STB    = wr_stb_q;
   assign fsm_state = state_q;

endmodule

// File: tb/tb_spi_regfile_slave.sv
// Bench for spi_regfile_slave: directed frames plus random frames, checked against a
// frame-level register-file model; idle cycles between frames are compared every CLK.
`timescale 1ns/1ps
module tb_spi_regfile_slave;

   logic        CLK = 1'b0;
   logic        NRST = 1'b0;
   logic        SPI_SCLK = 1'b0;
   logic        SPI_MOSI = 1'b0;
   logic        SPI_SS = 1'b1;
   logic        SPI_MISO, MISO_OE, WR_STB;
   logic [3:0]  LEDPORT;
   logic [15:0] PWMPORT;
   logic [1:0]  fsm_state;

   spi_regfile_slave #(.LED_W(4), .NUM_PWM(2), .LSB_FIRST(1)) dut (
      .CLK(CLK), .NRST(NRST), .SPI_SCLK(SPI_SCLK), .SPI_MOSI(SPI_MOSI), .SPI_SS(SPI_SS),
      .SPI_MISO(SPI_MISO), .MISO_OE(MISO_OE), .LEDPORT(LEDPORT), .PWMPORT(PWMPORT),
      .WR_STB(WR_STB), .fsm_state(fsm_state)
   );

   // clock / reset: 50 MHz system clock; reset is driven from the main sequence
   always #10 CLK = ~CLK;

   int total = 0;
   int bad = 0;
   int stb_cnt = 0;
   int exp_stb = 0;
   bit chk_en = 1'b0;

   // model state
   logic [3:0] m_led = '0;
   logic [7:0] m_pwm [2] = '{8'h00, 8'h00};
   logic       m_err = 1'b0;
   logic       m_ovr = 1'b0;
   logic [7:0] fb [8];
   logic [7:0] rb [8];
   logic [7:0] em [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // scoreboard: between frames the DUT must hold exactly the model's registers
   always @(negedge CLK) begin
      if (WR_STB === 1'b1) stb_cnt++;
      if (chk_en) begin
         check("idle_led", 32'(LEDPORT), 32'(m_led));
         check("idle_pwm", 32'(PWMPORT), 32'({m_pwm[1], m_pwm[0]}));
         check("idle_oe", 32'(MISO_OE), 32'd0);
         check("idle_miso", 32'(SPI_MISO), 32'd0);
         check("idle_stb", 32'(WR_STB), 32'd0);
      end
   end

   // frame-level model: apply the complete bytes of fb[] and predict each MISO byte
   task automatic model_frame(input int nbits);
      int nb;
      int idx;
      logic [7:0] cmd;
      nb = nbits / 8;
      idx = 0;
      exp_stb = 0;
      for (int k = 0; k < 8; k++) em[k] = 8'h00;
      if (nb == 0) return;
      cmd = fb[0];
      for (int k = 1; k < nb; k++) begin
         case (cmd)
            8'h01: begin m_led = fb[k][3:0]; exp_stb++; end
            8'h02: em[k] = {4'h0, m_led};
            8'h04: begin m_pwm[idx] = fb[k]; idx = (idx + 1) % 2; exp_stb++; end
            8'h05: begin em[k] = m_pwm[idx]; idx = (idx + 1) % 2; end
            8'h06: em[k] = 8'h71;
            8'h07: em[k] = (k == 1) ? {6'b0, m_ovr, m_err} : 8'h00;
            default: ;
         endcase
      end
      if (cmd == 8'h07) begin m_err = 1'b0; m_ovr = 1'b0; end
      else if (!(cmd inside {8'h01, 8'h02, 8'h04, 8'h05, 8'h06})) m_err = 1'b1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_led"}, 32'(LEDPORT), 32'd0);
      check({tag, "_pwm"}, 32'(PWMPORT), 32'd0);
      check({tag, "_miso"}, 32'(SPI_MISO), 32'd0);
      check({tag, "_oe"}, 32'(MISO_OE), 32'd0);
      check({tag, "_stb"}, 32'(WR_STB), 32'd0);
   endtask

   // driver: one mode-0 frame of nbits bits from fb[], LSB first; NRST pulsed before bit rst_bit
   task automatic spi_frame(input int nbits, input int rst_bit);
      for (int b = 0; b < 8; b++) rb[b] = 8'h00;
      stb_cnt = 0;
      SPI_SS = 1'b0;
      #150;
      for (int i = 0; i < nbits; i++) begin
         if (i == rst_bit) begin
            NRST = 1'b0;
            #50;
            check_reset_outputs("midreset");
            #100;
            NRST = 1'b1;
            #100;
         end
         if (i == 0) check("oe_active", 32'(MISO_OE), 32'd1);
         SPI_MOSI = fb[i / 8][i % 8];
         #100;
         SPI_SCLK = 1'b1;
         rb[i / 8][i % 8] = SPI_MISO;
         #100;
         SPI_SCLK = 1'b0;
      end
      #100;
      SPI_SS = 1'b1;
      SPI_MOSI = 1'b0;
      #200;
   endtask

   task automatic run_frame(input int nbits, input int rst_bit);
      logic [7:0] cmd;
      cmd = fb[0];
      spi_frame(nbits, rst_bit);
      if (rst_bit >= 0) begin
         m_led = '0; m_pwm[0] = '0; m_pwm[1] = '0; m_err = 1'b0; m_ovr = 1'b0;
         exp_stb = 0;
      end else begin
         model_frame(nbits);
         if (nbits >= 8) check("miso_cmd_byte", 32'(rb[0]), 32'd0);
         if (cmd inside {8'h02, 8'h05, 8'h06, 8'h07} || nbits < 8 || rst_bit >= 0) begin
            for (int k = 1; k < nbits / 8; k++) check("miso_byte", 32'(rb[k]), 32'(em[k]));
         end
      end
      check("wr_stb_count", 32'(stb_cnt), 32'(exp_stb));
      chk_en = 1'b1;
      #300;
      chk_en = 1'b0;
      #50;
   endtask

   task automatic ovr_frame();
      SPI_SS = 1'b0;
      #150;
      SPI_SCLK = 1'b1;
      SPI_SS = 1'b1;
      #100;
      SPI_SCLK = 1'b0;
      #200;
      m_ovr = 1'b1;
   endtask

   initial begin
      int nb, nbits, r;
      #5;
      #100;
      check_reset_outputs("reset");
      NRST = 1'b1;
      #200;

      fb[0] = 8'h01; fb[1] = 8'h0A;
      run_frame(16, -1);
      check("t1_led", 32'(LEDPORT), 32'hA);
      check("t1_pwm", 32'(PWMPORT), 32'h0);
      check("t1_stb", 32'(stb_cnt), 32'd1);

      fb[0] = 8'h04; fb[1] = 8'h11; fb[2] = 8'h22; fb[3] = 8'h33;
      run_frame(32, -1);
      check("t2_pwm", 32'(PWMPORT), 32'h2233);
      check("t2_stb", 32'(stb_cnt), 32'd3);

      fb[0] = 8'h06; fb[1] = 8'h00; fb[2] = 8'h00;
      run_frame(24, -1);
      check("t3_id0", 32'(rb[0]), 32'h00);
      check("t3_id1", 32'(rb[1]), 32'h71);
      check("t3_id2", 32'(rb[2]), 32'h71);

      fb[0] = 8'h09; fb[1] = 8'h55;
      run_frame(16, -1);
      check("t4_led", 32'(LEDPORT), 32'hA);
      fb[0] = 8'h07; fb[1] = 8'h00;
      run_frame(16, -1);
      check("t4_stat_err", 32'(rb[1]), 32'h01);
      run_frame(16, -1);
      check("t4_stat_clr", 32'(rb[1]), 32'h00);

      fb[0] = 8'h04; fb[1] = 8'h99;
      run_frame(13, -1);
      check("t5_pwm", 32'(PWMPORT), 32'h2233);
      fb[0] = 8'h05; fb[1] = 8'h00; fb[2] = 8'h00;
      run_frame(24, -1);
      check("t5_ch0", 32'(rb[1]), 32'h33);
      check("t5_ch1", 32'(rb[2]), 32'h22);

      fb[0] = 8'h01; fb[1] = 8'h0F;
      run_frame(16, 12);
      check("t6_led", 32'(LEDPORT), 32'h0);
      fb[0] = 8'h02; fb[1] = 8'h00;
      run_frame(16, -1);
      check("t6_rd_led", 32'(rb[1]), 32'h00);

      ovr_frame();
      fb[0] = 8'h07; fb[1] = 8'h00;
      run_frame(16, -1);
      check("ovr_stat", 32'(rb[1]), 32'h02);

      for (int f = 0; f < 30; f++) begin
         r = $urandom_range(0, 6);
         case (r)
            0: fb[0] = 8'h01;
            1: fb[0] = 8'h02;
            2: fb[0] = 8'h04;
            3: fb[0] = 8'h05;
            4: fb[0] = 8'h06;
            5: fb[0] = 8'h07;
            default: fb[0] = 8'($urandom_range(8, 255));
         endcase
         nb = $urandom_range(1, 5);
         for (int k = 1; k < 8; k++) fb[k] = 8'($urandom_range(0, 255));
         nbits = nb * 8;
         if ($urandom_range(0, 4) == 0) nbits = nbits - $urandom_range(1, 7);
         run_frame(nbits, -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
